mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (IF) and data port (MEM).
- Serialises requests through a small FSM: data has priority over instruction.
- Drives per-port stall signals back to the pipeline control.
- A watchdog aborts accesses the memory never acknowledges and raises a sticky error.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_watchdog.sv | 20 ++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the IF/MEM memory arbiter: FSM state encoding and
// the default watchdog limit.
package mem_arb_pkg;
  localparam logic [2:0] ARB_IDLE      = 3'd0;
  localparam logic [2:0] ARB_BUSY_DATA = 3'd1;
  localparam logic [2:0] ARB_BUSY_INST = 3'd2;
  localparam logic [2:0] ARB_RESP_DATA = 3'd3;
  localparam logic [2:0] ARB_RESP_INST = 3'd4;

  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter for an outstanding memory access; expire flags the last
// cycle the access may remain in flight.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 16'd1;
  end

  assign expire = (cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM requests onto one single-ported memory, data first,
// with a watchdog that aborts unacknowledged accesses and sets a sticky error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_stall,
  input  logic                  data_ren,
  input  logic                  data_wen,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_dout,
  output logic [DATA_WIDTH-1:0] data_din,
  output logic                  data_stall,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dout,
  input  logic [DATA_WIDTH-1:0] ram_din,
  input  logic                  ram_ack,
  output logic                  bus_err
);
  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] result;
  logic                  busy;
  logic                  wd_expire;

  assign busy = (state == ARB_BUSY_DATA) || (state == ARB_BUSY_INST);

  // Counter runs only while an access is in flight and restarts at its end.
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy || ram_ack || wd_expire),
    .en     (busy),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_dout <= '0;
      result   <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (data_ren || data_wen) begin
            ram_addr <= data_addr;
            ram_dout <= data_dout;
            ram_we   <= data_wen;
            ram_cs   <= 1'b1;
            state    <= ARB_BUSY_DATA;
          end else if (inst_ren) begin
            ram_addr <= inst_addr;
            ram_we   <= 1'b0;
            ram_cs   <= 1'b1;
            state    <= ARB_BUSY_INST;
          end
        end
        ARB_BUSY_DATA, ARB_BUSY_INST: begin
          // Ack is checked first so a last-cycle ack is not reported as an error.
          if (ram_ack) begin
            result <= ram_we ? '0 : ram_din;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            state  <= (state == ARB_BUSY_DATA) ? ARB_RESP_DATA : ARB_RESP_INST;
          end else if (wd_expire) begin
            result  <= '0;
            bus_err <= 1'b1;
            ram_cs  <= 1'b0;
            ram_we  <= 1'b0;
            state   <= (state == ARB_BUSY_DATA) ? ARB_RESP_DATA : ARB_RESP_INST;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign inst_stall = inst_ren && (state != ARB_RESP_INST);
  assign data_stall = (data_ren || data_wen) && (state != ARB_RESP_DATA);
  assign inst_data  = (state == ARB_RESP_INST) ? result : '0;
  assign data_din   = (state == ARB_RESP_DATA) ? result : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a short watchdog (TIMEOUT=8).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        data_ren = 1'b0;
  logic        data_wen = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_dout = '0;
  logic [31:0] data_din;
  logic        data_stall;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_dout;
  logic [31:0] ram_din = '0;
  logic        ram_ack = 1'b0;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr), .data_dout(data_dout),
    .data_din(data_din), .data_stall(data_stall),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_ack(ram_ack), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_cs", 32'(ram_cs), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dout", ram_dout, 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_idata", inst_data, 0);
    chk("rst_ddata", data_din, 0);
    rst = 1'b0;

    // Single fetch, ack in first BUSY cycle
    inst_ren = 1'b1; inst_addr = 32'h40;
    #1 chk("f_stall0", 32'(inst_stall), 1);
    tick();
    chk("f_cs", 32'(ram_cs), 1);
    chk("f_addr", ram_addr, 32'h40);
    chk("f_we", 32'(ram_we), 0);
    ram_ack = 1'b1; ram_din = 32'h2002000A;
    tick();
    ram_ack = 1'b0;
    chk("f_stall2", 32'(inst_stall), 0);
    chk("f_data", inst_data, 32'h2002000A);
    chk("f_ddin", data_din, 0);
    chk("f_cs2", 32'(ram_cs), 0);
    inst_ren = 1'b0;
    tick();

    // Simultaneous requests: data first, then instruction
    inst_ren = 1'b1; inst_addr = 32'h44; data_ren = 1'b1; data_addr = 32'h100;
    tick();
    chk("s_addr_d", ram_addr, 32'h100);
    chk("s_istall_b", 32'(inst_stall), 1);
    chk("s_dstall_b", 32'(data_stall), 1);
    ram_ack = 1'b1; ram_din = 32'h11112222;
    tick();
    ram_ack = 1'b0;
    chk("s_dstall_r", 32'(data_stall), 0);
    chk("s_istall_r", 32'(inst_stall), 1);
    chk("s_ddin", data_din, 32'h11112222);
    chk("s_idata0", inst_data, 0);
    data_ren = 1'b0;
    tick();
    chk("s_idle_cs", 32'(ram_cs), 0);
    chk("s_idle_istall", 32'(inst_stall), 1);
    tick();
    chk("s_cs_i", 32'(ram_cs), 1);
    chk("s_addr_i", ram_addr, 32'h44);
    ram_ack = 1'b1; ram_din = 32'h33334444;
    tick();
    ram_ack = 1'b0;
    chk("s_idata", inst_data, 32'h33334444);
    chk("s_istall_ri", 32'(inst_stall), 0);
    inst_ren = 1'b0;
    tick();

    // Store held for 4 BUSY cycles, result forced to 0
    data_wen = 1'b1; data_addr = 32'h200; data_dout = 32'hDEADBEEF; ram_din = 32'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("w_cs%0d", i), 32'(ram_cs), 1);
      chk($sformatf("w_we%0d", i), 32'(ram_we), 1);
      chk($sformatf("w_dout%0d", i), ram_dout, 32'hDEADBEEF);
      chk($sformatf("w_addr%0d", i), ram_addr, 32'h200);
      data_dout = 32'h0BAD0BAD;
      if (i == 3) ram_ack = 1'b1;
    end
    tick();
    ram_ack = 1'b0;
    chk("w_dstall", 32'(data_stall), 0);
    chk("w_ddin", data_din, 0);
    data_wen = 1'b0;
    tick();

    // Timeout: never ack, expect exactly 8 BUSY cycles
    inst_ren = 1'b1; inst_addr = 32'h80;
    tick();
    n_busy = 0;
    while (ram_cs && n_busy < 20) begin
      n_busy++;
      tick();
    end
    chk("t_busy_cycles", 32'(n_busy), 8);
    chk("t_istall", 32'(inst_stall), 0);
    chk("t_idata", inst_data, 0);
    chk("t_err", 32'(bus_err), 1);
    inst_ren = 1'b0;
    tick();
    data_ren = 1'b1; data_addr = 32'h300;
    tick();
    ram_ack = 1'b1; ram_din = 32'h77778888;
    tick();
    ram_ack = 1'b0;
    chk("t_good_data", data_din, 32'h77778888);
    chk("t_err_sticky", 32'(bus_err), 1);
    data_ren = 1'b0;
    tick();

    // Reset in the 2nd BUSY cycle, late ack ignored
    data_ren = 1'b1; data_addr = 32'h400;
    tick(); tick();
    chk("r_cs_busy2", 32'(ram_cs), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; data_ren = 1'b0; ram_ack = 1'b1; ram_din = 32'h99;
    chk("r_cs", 32'(ram_cs), 0);
    chk("r_err", 32'(bus_err), 0);
    chk("r_addr", ram_addr, 0);
    tick();
    chk("r_late_cs", 32'(ram_cs), 0);
    chk("r_late_ddin", data_din, 0);
    chk("r_late_idata", inst_data, 0);
    ram_ack = 1'b0;
    tick();

    // Ack on the final timeout cycle wins
    inst_ren = 1'b1; inst_addr = 32'h88;
    tick();
    for (int i = 1; i < 8; i++) tick();
    chk("a_cs8", 32'(ram_cs), 1);
    ram_ack = 1'b1; ram_din = 32'hCAFEF00D;
    tick();
    ram_ack = 1'b0;
    chk("a_istall", 32'(inst_stall), 0);
    chk("a_idata", inst_data, 32'hCAFEF00D);
    chk("a_err", 32'(bus_err), 0);
    inst_ren = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
